// File: rtl/bcd_converter_if.sv
// Handshake and result bundle between the product source, the converter and
// the seven-segment driver. Signal names follow the converter's port list.
interface bcd_converter_if #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
);
    logic                  start;
    logic [WIDTH-1:0]      product;
    logic                  busy;
    logic                  done;
    logic                  sign;
    logic [4*DIGITS-1:0]   bcd;

    // Requester side: issues start/product, observes status and result.
    modport master (
        output start,
        output product,
        input  busy,
        input  done,
        input  sign,
        input  bcd
    );

    // Converter side.
    modport slave (
        input  start,
        input  product,
        output busy,
        output done,
        output sign,
        output bcd
    );
endinterface

// File: rtl/bcd_converter.sv
// Signed binary to BCD converter using shift-and-add-3 (double dabble),
// one product bit per clock. Result is a sign flag plus packed BCD magnitude,
// digit 0 (ones) in bits [3:0]. All outputs are registered.
module bcd_converter #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic            clk,
    input  logic            rst,
    bcd_converter_if.slave  bus
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] mag_q, mag_d;
    logic [BW-1:0]   scratch_q, scratch_d;
    logic            sign_r_q, sign_r_d;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic            sign_q, sign_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    // Scratch digits after the parallel +3 correction of this iteration.
    logic [BW-1:0]   adj;

    // State and datapath registers; reset clears everything, including any
    // conversion in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            mag_q     <= '0;
            scratch_q <= '0;
            sign_r_q  <= 1'b0;
            bcd_q     <= '0;
            sign_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mag_q     <= mag_d;
            scratch_q <= scratch_d;
            sign_r_q  <= sign_r_d;
            bcd_q     <= bcd_d;
            sign_q    <= sign_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next-state logic: exactly WIDTH SHIFT iterations, then one FINISH cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = SHIFT;
            SHIFT:   if (cnt_q == CW'(1)) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next values.
    always_comb begin
        for (int d = 0; d < DIGITS; d++) begin
            adj[d*4 +: 4] = (scratch_q[d*4 +: 4] >= 4'd5) ? scratch_q[d*4 +: 4] + 4'd3
                                                          : scratch_q[d*4 +: 4];
        end

        cnt_d     = cnt_q;
        mag_d     = mag_q;
        scratch_d = scratch_q;
        sign_r_d  = sign_r_q;
        bcd_d     = bcd_q;
        sign_d    = sign_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sign_r_d  = bus.product[WIDTH-1];
                    // Unsigned reinterpretation keeps -2^(WIDTH-1) exact.
                    mag_d     = bus.product[WIDTH-1] ? (~bus.product + 1'b1) : bus.product;
                    scratch_d = '0;
                    cnt_d     = CW'(WIDTH);
                end
            end
            SHIFT: begin
                {scratch_d, mag_d} = {adj[BW-2:0], mag_q, 1'b0};
                cnt_d = cnt_q - CW'(1);
            end
            FINISH: begin
                bcd_d  = scratch_q;
                sign_d = sign_r_q;
            end
            default: ;
        endcase

        // done lands together with the new bcd/sign, one cycle after FINISH.
        busy_d = (state_d != IDLE);
        done_d = (state_q == FINISH);
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sign = sign_q;
    assign bus.bcd  = bcd_q;
endmodule

// File: tb/tb_bcd_converter.sv
// Directed testbench for bcd_converter: latency, sign/magnitude results,
// busy-start rejection, mid-conversion reset and back-to-back requests.
module tb_bcd_converter;
    localparam int WIDTH  = 16;
    localparam int DIGITS = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   pass_cnt = 0;
    int   total    = 0;

    bcd_converter_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

    bcd_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Accept a conversion (caller sits at a negedge), then wait for done.
    // lat = edges from acceptance to the negedge where done is seen,
    // bcnt = negedges with busy high, to = no done within budget.
    task automatic run(input logic [15:0] p, output int lat, output int bcnt, output bit to);
        bus.start   = 1'b1;
        bus.product = p;
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        bus.product = 16'h5A5A;
        lat = 0; bcnt = 0; to = 1'b1;
        @(negedge clk);
        if (bus.busy) bcnt++;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.busy) bcnt++;
            if (bus.done) begin
                lat = i; to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.product = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({bus.busy, bus.done, bus.sign, bus.bcd} !== 23'd0)
            $display("FAIL reset_state: got busy=%b done=%b sign=%b bcd=%h, want all 0",
                     bus.busy, bus.done, bus.sign, bus.bcd);
        else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_zero();
        int lat, bcnt; bit to;
        run(16'h0000, lat, bcnt, to);
        total++;
        if (to || lat != 17) $display("FAIL zero_latency: got %0d (timeout=%b), want 17", lat, to);
        else pass_cnt++;
        total++;
        if (bcnt != 17) $display("FAIL zero_busy_cycles: got %0d, want 17", bcnt);
        else pass_cnt++;
        total++;
        if (bus.bcd !== 20'h00000 || bus.sign !== 1'b0)
            $display("FAIL zero_result: got sign=%b bcd=%h, want 0/00000", bus.sign, bus.bcd);
        else pass_cnt++;
        @(negedge clk);
        total++;
        if (bus.done !== 1'b0) $display("FAIL done_single_pulse: got %b, want 0", bus.done);
        else pass_cnt++;
    endtask

    task automatic test_positive();
        logic [15:0] p [2]   = '{16'h3039, 16'h7FFF};
        logic [19:0] e [2]   = '{20'h12345, 20'h32767};
        int lat, bcnt; bit to;
        for (int i = 0; i < 2; i++) begin
            run(p[i], lat, bcnt, to);
            total++;
            if (to || bus.bcd !== e[i] || bus.sign !== 1'b0)
                $display("FAIL positive_%0d: got sign=%b bcd=%h to=%b, want 0/%h",
                         i, bus.sign, bus.bcd, to, e[i]);
            else pass_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_negative();
        logic [15:0] p [2]   = '{16'hFFFF, 16'h8000};
        logic [19:0] e [2]   = '{20'h00001, 20'h32768};
        int lat, bcnt; bit to;
        for (int i = 0; i < 2; i++) begin
            run(p[i], lat, bcnt, to);
            total++;
            if (to || bus.bcd !== e[i] || bus.sign !== 1'b1)
                $display("FAIL negative_%0d: got sign=%b bcd=%h to=%b, want 1/%h",
                         i, bus.sign, bus.bcd, to, e[i]);
            else pass_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_busy_ignore();
        int dones = 0;
        int first = 0;
        bus.start = 1'b1; bus.product = 16'h0064;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            // Start pulses sampled at edges k+5 and k+17 (the FINISH cycle).
            bus.start   = (c == 5 || c == 17);
            bus.product = 16'h0001;
            @(posedge clk); #1;
            bus.start = 1'b0;
            @(negedge clk);
            if (bus.done) begin
                dones++;
                if (first == 0) first = c;
            end
        end
        total++;
        if (dones != 1 || first != 17)
            $display("FAIL busy_ignore_done: got %0d pulses first at %0d, want 1 at 17", dones, first);
        else pass_cnt++;
        total++;
        if (bus.bcd !== 20'h00100 || bus.sign !== 1'b0)
            $display("FAIL busy_ignore_result: got sign=%b bcd=%h, want 0/00100", bus.sign, bus.bcd);
        else pass_cnt++;
    endtask

    task automatic test_reset_abort();
        int dones = 0;
        int lat, bcnt; bit to;
        @(negedge clk);
        bus.start = 1'b1; bus.product = 16'h3039;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (bus.busy !== 1'b0 || bus.bcd !== 20'h0 || bus.sign !== 1'b0)
            $display("FAIL reset_abort_state: got busy=%b sign=%b bcd=%h, want 0/0/00000",
                     bus.busy, bus.sign, bus.bcd);
        else pass_cnt++;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        total++;
        if (dones != 0 || bus.bcd !== 20'h0)
            $display("FAIL reset_abort_no_done: got %0d pulses bcd=%h, want 0/00000", dones, bus.bcd);
        else pass_cnt++;
        run(16'hFF85, lat, bcnt, to);
        total++;
        if (to || bus.bcd !== 20'h00123 || bus.sign !== 1'b1)
            $display("FAIL after_reset_neg123: got sign=%b bcd=%h to=%b, want 1/00123",
                     bus.sign, bus.bcd, to);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat, bcnt; bit to;
        int held_bad = 0;
        int lat2 = 0;
        run(16'd42, lat, bcnt, to);
        total++;
        if (to || bus.bcd !== 20'h00042 || bus.sign !== 1'b0)
            $display("FAIL b2b_first: got sign=%b bcd=%h to=%b, want 0/00042", bus.sign, bus.bcd, to);
        else pass_cnt++;
        // Still in the done cycle: request the next one immediately.
        bus.start = 1'b1; bus.product = 16'hFFD6;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        total++;
        if (bus.busy !== 1'b1) $display("FAIL b2b_accept: got busy=%b, want 1", bus.busy);
        else pass_cnt++;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.done) begin
                lat2 = i;
                break;
            end
            if (bus.bcd !== 20'h00042 || bus.sign !== 1'b0) held_bad++;
        end
        total++;
        if (held_bad != 0) $display("FAIL b2b_hold: got %0d cycles with changed result, want 0", held_bad);
        else pass_cnt++;
        total++;
        if (lat2 != 17) $display("FAIL b2b_latency: got %0d, want 17", lat2);
        else pass_cnt++;
        total++;
        if (bus.bcd !== 20'h00042 || bus.sign !== 1'b1)
            $display("FAIL b2b_second: got sign=%b bcd=%h, want 1/00042", bus.sign, bus.bcd);
        else pass_cnt++;
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.product = '0;
        test_reset();
        test_zero();
        test_positive();
        test_negative();
        test_busy_ignore();
        test_reset_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/bcd_converter.md
Name: bcd_converter

Overview:
Sequential signed binary-to-BCD converter downstream of the multiplier datapath. It consumes the signed product once the control unit reports completion (done LED state). It produces a sign flag plus packed BCD magnitude digits for the seven-segment display driver. It uses the shift-and-add-3 (double-dabble) algorithm, one bit per clock, with a start/done handshake.

Parameters:
WIDTH, 16, width of the signed two's-complement product input
DIGITS, 5, number of BCD output digits; must be at least ceil(WIDTH*log10(2)), which is 5 for 16

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request conversion of product; sampled on the clk rising edge
product  input  WIDTH  signed two's-complement value; captured only when start is accepted
busy  output  1  conversion in progress; start is ignored while high
done  output  1  single-cycle pulse; bcd and sign are valid in this cycle
sign  output  1  1 = product was negative
bcd  output  4*DIGITS  packed BCD magnitude; digit 0 (ones) in bits [3:0]

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, busy=0, done=0, sign=0, bcd=0, bit counter=0, scratch registers=0. Reset overrides start and aborts a conversion in progress. No partial result reaches bcd.
- State machine has three states: IDLE, SHIFT, FINISH.
- IDLE:
  - start=1 is accepted.
  - sign_r <= product[WIDTH-1].
  - mag <= |product| as a WIDTH-bit unsigned value. The most negative value -2^(WIDTH-1) maps to 2^(WIDTH-1) with no overflow.
  - scratch BCD <= 0, counter <= WIDTH, next state=SHIFT.
  - start=0: remain in IDLE.
- SHIFT, one iteration per cycle:
  - Every scratch digit >=5 gets +3, all digits in parallel.
  - The adjusted {scratch, mag} is then shifted left by 1, so mag MSB enters scratch digit-0 LSB.
  - Counter decrements. When counter reaches 1 in this cycle, next state=FINISH. Exactly WIDTH iterations run.
- FINISH (one cycle): bcd <= scratch, sign <= sign_r, done=1, next state=IDLE.
- busy=1 in SHIFT and FINISH, 0 in IDLE. done=1 only in FINISH.
- Latency: if start is accepted at edge k, done is high during the cycle following edge k+WIDTH+1. For the default, that is 17 edges after acceptance.
- start while busy=1, including the FINISH cycle: ignored, not queued. product changes while busy: no effect.
- Back-to-back: start asserted in the first IDLE cycle after done is accepted immediately.
- bcd and sign hold their last completed values until the next FINISH or reset; they do not change during SHIFT.
- Zero input gives sign=0 and bcd=0. Negative zero is not possible.
- done and busy are registered outputs, with no combinational path from start.

Test Plan:
1. Reset, then start with product=0x0000 -> done pulse exactly 17 edges after acceptance; bcd=0x00000, sign=0; busy high for 17 cycles.
2. Start with product=0x3039 (12345) -> bcd=0x12345, sign=0. Then product=0x7FFF -> bcd=0x32767, sign=0.
3. Start with product=0xFFFF (-1) -> bcd=0x00001, sign=1. Then product=0x8000 -> bcd=0x32768, sign=1 (no overflow).
4. Start with 0x0064 (100); pulse start with 0x0001 at cycles 5 and 17 (FINISH) -> both ignored; single done; bcd=0x00100.
5. Start with 0x3039; assert rst at cycle 8 -> busy=0, done never pulses, bcd=0, sign=0. Then start with 0xFF85 (-123) -> bcd=0x00123, sign=1.
6. Back-to-back: start with 42, then start again with -42 on the first cycle after done -> second done 17 edges later; bcd=0x00042, sign=1. Between the two completions, bcd=0x00042 and sign=0 are held.
